// File: rtl/qracc_sram_sequencer.sv
// Turns one SRAM read/write request into a timed precharge / wordline / sense
// sequence on the analog column array and returns captured sense-amp data.
module qracc_sram_sequencer #(
    parameter int numRows    = 128,
    parameter int numCols    = 32,
    parameter int PCH_CYCLES = 2,
    parameter int WL_CYCLES  = 2,
    parameter int SA_CYCLES  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rq_valid_i,
    input  logic                       rq_wr_i,
    input  logic [$clog2(numRows)-1:0] addr_i,
    input  logic [numCols-1:0]         wr_data_i,
    output logic                       rq_ready_o,
    output logic                       rd_valid_o,
    output logic [numCols-1:0]         rd_data_o,
    output logic [numRows-1:0]         WL,
    output logic                       PCH,
    output logic                       WRITE,
    output logic [numCols-1:0]         WR_DATA,
    output logic [numCols-1:0]         CSEL,
    output logic                       SAEN,
    input  logic [numCols-1:0]         SA_OUT
);

    localparam int AW = $clog2(numRows);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRECHARGE = 3'd1;
    localparam logic [2:0] WORDLINE  = 3'd2;
    localparam logic [2:0] SENSE     = 3'd3;
    localparam logic [2:0] RECOVER   = 3'd4;

    localparam logic [3:0] PCH_LEN = 4'(PCH_CYCLES);
    localparam logic [3:0] WL_LEN  = 4'(WL_CYCLES);
    localparam logic [3:0] SA_LEN  = 4'(SA_CYCLES);

    logic [2:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [numCols-1:0] data_q, data_d;

    logic               rd_valid_q, rd_valid_d;
    logic [numCols-1:0] rd_data_q, rd_data_d;
    logic [numRows-1:0] wl_q, wl_d;
    logic               pch_q, pch_d;
    logic               write_q, write_d;
    logic [numCols-1:0] wr_data_q, wr_data_d;
    logic [numCols-1:0] csel_q, csel_d;
    logic               saen_q, saen_d;

    logic accept;
    logic last;

    assign rq_ready_o = (state_q == IDLE) && !rst;
    assign accept     = rq_valid_i && rq_ready_o;
    // Phase counter is loaded with the phase length on entry; 1 marks the final cycle.
    assign last       = (cnt_q == 4'd1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q > 4'd1) ? cnt_q - 4'd1 : cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PRECHARGE;
                    cnt_d   = PCH_LEN;
                    wr_d    = rq_wr_i;
                    addr_d  = addr_i;
                    data_d  = wr_data_i;
                end
            end
            PRECHARGE: begin
                if (last) begin
                    state_d = WORDLINE;
                    cnt_d   = WL_LEN;
                end
            end
            WORDLINE: begin
                if (last) begin
                    state_d = wr_q ? RECOVER : SENSE;
                    cnt_d   = wr_q ? 4'd1 : SA_LEN;
                end
            end
            SENSE: begin
                if (last) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b1;
                    rd_data_d  = SA_OUT;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Analog controls are registered from the next state so the array never
    // sees a combinational path from the request inputs.
    always_comb begin
        wl_d = '0;
        if (state_d == WORDLINE) begin
            for (int r = 0; r < numRows; r++) begin
                wl_d[r] = (addr_q == AW'(r));
            end
        end
        pch_d     = (state_d == PRECHARGE);
        write_d   = (state_d == WORDLINE) && wr_q;
        wr_data_d = write_d ? data_q : '0;
        csel_d    = (state_d == WORDLINE || state_d == SENSE) ? '1 : '0;
        saen_d    = (state_d == SENSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wl_q       <= '0;
            pch_q      <= 1'b0;
            write_q    <= 1'b0;
            wr_data_q  <= '0;
            csel_q     <= '0;
            saen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            wl_q       <= wl_d;
            pch_q      <= pch_d;
            write_q    <= write_d;
            wr_data_q  <= wr_data_d;
            csel_q     <= csel_d;
            saen_q     <= saen_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign WL         = wl_q;
    assign PCH        = pch_q;
    assign WRITE      = write_q;
    assign WR_DATA    = wr_data_q;
    assign CSEL       = csel_q;
    assign SAEN       = saen_q;

endmodule

// File: doc/qracc_sram_sequencer.md
Name: qracc_sram_sequencer

Overview:
- Digital-to-analog sequencer that sits directly downstream of the SRAM request port (sram_itf slave side) and upstream of the analog column array.
- Converts one accepted read or write request into a timed precharge / wordline / sense-enable sequence, driving the SRAM fields of the analog control bundle (WL, PCH, WRITE, WR_DATA, CSEL, SAEN).
- Captures SA_OUT and returns read data with a one-cycle valid pulse.
- Serves one request at a time; no queueing.

Parameters:
numRows, 128, SRAM rows; width of WL; address width is $clog2(numRows)
numCols, 32, columns per bank; data width
PCH_CYCLES, 2, precharge phase length in cycles (legal range 1..15)
WL_CYCLES, 2, wordline phase length in cycles (legal range 1..15)
SA_CYCLES, 1, sense phase length in cycles, reads only (legal range 1..15)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
rq_valid_i  in  1  request valid
rq_wr_i  in  1  1 = write, 0 = read
addr_i  in  $clog2(numRows)  row address
wr_data_i  in  numCols  write data
rq_ready_o  out  1  ready to accept a request
rd_valid_o  out  1  one-cycle pulse; rd_data_o valid
rd_data_o  out  numCols  captured read data
WL  out  numRows  one-hot wordline
PCH  out  1  bitline precharge, active-high
WRITE  out  1  write driver enable
WR_DATA  out  numCols  write data to drivers
CSEL  out  numCols  column select
SAEN  out  1  sense-amp enable
SA_OUT  in  numCols  sense-amp outputs

Behaviour:
- Reset: state = IDLE. All outputs are 0, except rq_ready_o = 1 from the first cycle after rst deasserts. rst has priority over everything.
- Reset mid-sequence: the sequence aborts at that edge. WL, PCH, WRITE, SAEN, CSEL and WR_DATA are 0 the next cycle. No rd_valid_o is issued. rd_data_o is cleared.
- Handshake: a request is accepted on an edge where rq_valid_i & rq_ready_o. rq_ready_o = 1 only in IDLE.
  - On accept, rq_wr_i, addr_i and wr_data_i are latched. Later changes on those inputs are ignored until the next accept.
  - If rq_valid_i is held high with ready low, the request waits and is accepted on the first IDLE cycle.
- States: IDLE, PRECHARGE, WORDLINE, SENSE, RECOVER. All outputs are registered or decoded from state only; no combinational path from inputs to analog outputs.
- PRECHARGE (PCH_CYCLES cycles): PCH = 1. All other analog outputs are 0.
- WORDLINE (WL_CYCLES cycles):
  - WL = one-hot of the latched address, CSEL = all ones, PCH = 0.
  - Writes: WRITE = 1 and WR_DATA = latched data.
  - Reads: WRITE = 0 and WR_DATA = 0.
  - Address >= numRows: WL stays all zero; the sequence otherwise runs normally.
- Read: WORDLINE -> SENSE (SA_CYCLES cycles). In SENSE, SAEN = 1, WL = 0, CSEL = all ones.
  - On the edge ending the last SENSE cycle: rd_data_o <= SA_OUT, rd_valid_o <= 1, state -> IDLE.
- Write: WORDLINE -> RECOVER (1 cycle, all analog outputs 0) -> IDLE. rd_valid_o is never asserted for writes.
- Timing, for an accept on the edge ending cycle T:
  - PRECHARGE occupies T+1 .. T+PCH_CYCLES.
  - Read: rd_valid_o is high in cycle T+PCH_CYCLES+WL_CYCLES+SA_CYCLES+1, i.e. T+6 at defaults.
  - Write: IDLE is re-entered at T+PCH_CYCLES+WL_CYCLES+2, i.e. T+6 at defaults.
- Back-to-back: rq_ready_o is high in the same cycle as rd_valid_o, so a new request can be accepted in that cycle.
- rd_valid_o is exactly 1 cycle wide. rd_data_o holds its value until the next read capture or reset.
- Invariants:
  - PCH and any WL bit are never high in the same cycle.
  - SAEN and WRITE are never high in the same cycle.
  - At most one WL bit is high.
- Phase counter is 4 bits. It loads on each state entry and counts down to 1.

Test Plan:
- Write addr 5, data 0xDEADBEEF at cycle T -> PCH high T+1..T+2; WL[5], WRITE and CSEL = 0xFFFFFFFF high T+3..T+4; WR_DATA = 0xDEADBEEF in T+3..T+4; rq_ready_o back high at T+6; no rd_valid_o.
- Read addr 127 with SA_OUT model returning 0xA5A5_0F0F -> WL[127] high T+3..T+4, SAEN high T+5, rd_valid_o pulses at T+6 with rd_data_o = 0xA5A50F0F, which holds afterwards.
- rq_valid_i held high for 3 back-to-back reads (addr 0, 1, 2) -> accepts 6 cycles apart; each rd_valid_o coincides with rq_ready_o = 1; every WL assertion is one-hot and never overlaps PCH.
- rst asserted during WORDLINE of a write -> next cycle WL = 0, WRITE = 0, PCH = 0, CSEL = 0; rq_ready_o = 1 after rst drops; no rd_valid_o.
- Inputs change after accept (addr_i 9 -> 3, wr_data_i 0x1 -> 0x2) -> WL[9] and WR_DATA = 0x1 are used.
- Parameters PCH=1, WL=3, SA=2, read -> rd_valid_o at T+7; SAEN high for exactly 2 cycles.
